// File: rtl/trapseq_pkg.sv
// Shared configuration type, CSR addresses and mstatus bit positions for the trap sequencer.
package trapseq_pkg;

  typedef struct packed {
    int unsigned XLEN;
    bit          S_SUPPORTED;
    logic [1:0]  U_MODE;
    logic [1:0]  S_MODE;
    logic [1:0]  M_MODE;
  } cvw_t;

  localparam cvw_t DefaultCfg = '{
    XLEN: 32, S_SUPPORTED: 1'b1, U_MODE: 2'b00, S_MODE: 2'b01, M_MODE: 2'b11
  };

  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;
  localparam logic [11:0] CsrMtval   = 12'h343;
  localparam logic [11:0] CsrSepc    = 12'h141;
  localparam logic [11:0] CsrScause  = 12'h142;
  localparam logic [11:0] CsrStval   = 12'h143;

  localparam int unsigned StatusSie   = 1;
  localparam int unsigned StatusMie   = 3;
  localparam int unsigned StatusSpie  = 5;
  localparam int unsigned StatusMpie  = 7;
  localparam int unsigned StatusSpp   = 8;
  localparam int unsigned StatusMppLo = 11;
  localparam int unsigned StatusMppHi = 12;

endpackage

// File: rtl/trapseq_trapvec.sv
// Combinational redirect target and next privilege for trap entry or trap return.
module trapvec
  import trapseq_pkg::*;
#(
  parameter cvw_t P = DefaultCfg
) (
  input  logic              trap,
  input  logic              interrupt,
  input  logic              deleg,
  input  logic [3:0]        cause,
  input  logic              mret,
  input  logic [1:0]        ret_priv,
  input  logic [P.XLEN-1:0] mtvec,
  input  logic [P.XLEN-1:0] stvec,
  input  logic [P.XLEN-1:0] mepc,
  input  logic [P.XLEN-1:0] sepc,
  output logic [P.XLEN-1:0] target,
  output logic [1:0]        priv
);

  logic [P.XLEN-1:0] tvec;
  logic [P.XLEN-1:0] base;
  logic [P.XLEN-1:0] offset;

  always_comb begin
    tvec        = deleg ? stvec : mtvec;
    base        = {tvec[P.XLEN-1:2], 2'b00};
    offset      = '0;
    offset[5:2] = cause;
    if (trap) begin
      // Vectored mode only applies to interrupts; the add wraps at XLEN.
      target = ((tvec[1:0] == 2'b01) && interrupt) ? base + offset : base;
      priv   = deleg ? P.S_MODE : P.M_MODE;
    end else begin
      target = mret ? mepc : sepc;
      priv   = ret_priv;
    end
  end

endmodule

// File: rtl/trapseq.sv
// Trap entry / return sequencer: serializes CSR writes over one port, then redirects the PC.
module trapseq
  import trapseq_pkg::*;
#(
  parameter cvw_t P = DefaultCfg
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              TrapM,
  input  logic              RetM,
  input  logic              mretM,
  input  logic              sretM,
  input  logic              InterruptM,
  input  logic              DelegateM,
  input  logic [3:0]        CauseM,
  input  logic [P.XLEN-1:0] PCM,
  input  logic [P.XLEN-1:0] TvalM,
  input  logic [1:0]        PrivilegeModeW,
  input  logic [P.XLEN-1:0] STATUS_REGW,
  input  logic [P.XLEN-1:0] MTVEC_REGW,
  input  logic [P.XLEN-1:0] STVEC_REGW,
  input  logic [P.XLEN-1:0] MEPC_REGW,
  input  logic [P.XLEN-1:0] SEPC_REGW,
  output logic              CSRSeqValid,
  input  logic              CSRSeqReady,
  output logic [11:0]       CSRSeqAdr,
  output logic [P.XLEN-1:0] CSRSeqData,
  output logic              SeqStallM,
  output logic              RedirectValid,
  output logic [P.XLEN-1:0] RedirectPC,
  output logic [1:0]        PrivilegeModeNext
);

  typedef enum logic [2:0] {
    StIdle, StWrEpc, StWrCause, StWrTval, StWrStatus, StRetStatus, StRedirect
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cause_q;
  logic              intr_q, deleg_q, mret_q, trap_q;
  logic [P.XLEN-1:0] pc_q, tval_q;
  logic [1:0]        priv_q, ret_priv_q, ret_priv_new;
  logic [P.XLEN-1:0] status_trap, status_ret;
  logic [P.XLEN-1:0] target;
  logic [1:0]        priv_next;

  assign ret_priv_new = mret_q ? STATUS_REGW[StatusMppHi:StatusMppLo]
                               : {1'b0, STATUS_REGW[StatusSpp]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cause_q    <= '0;
      intr_q     <= 1'b0;
      deleg_q    <= 1'b0;
      mret_q     <= 1'b0;
      trap_q     <= 1'b0;
      pc_q       <= '0;
      tval_q     <= '0;
      priv_q     <= '0;
      ret_priv_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && TrapM) begin
        cause_q <= CauseM;
        intr_q  <= InterruptM;
        deleg_q <= DelegateM & P.S_SUPPORTED;
        pc_q    <= PCM;
        tval_q  <= TvalM;
        priv_q  <= PrivilegeModeW;
        trap_q  <= 1'b1;
      end else if (state_q == StIdle && RetM) begin
        mret_q  <= mretM | ~sretM;
        deleg_q <= 1'b0;
        trap_q  <= 1'b0;
      end
      // mstatus changes once the write lands, so keep the pre-write privilege.
      if (state_q == StRetStatus && CSRSeqReady) ret_priv_q <= ret_priv_new;
    end
  end

  always_comb begin
    status_trap = STATUS_REGW;
    if (deleg_q) begin
      status_trap[StatusSpie] = STATUS_REGW[StatusSie];
      status_trap[StatusSie]  = 1'b0;
      status_trap[StatusSpp]  = priv_q[0];
    end else begin
      status_trap[StatusMpie]              = STATUS_REGW[StatusMie];
      status_trap[StatusMie]               = 1'b0;
      status_trap[StatusMppHi:StatusMppLo] = priv_q;
    end
    status_ret = STATUS_REGW;
    if (mret_q) begin
      status_ret[StatusMie]               = STATUS_REGW[StatusMpie];
      status_ret[StatusMpie]              = 1'b1;
      status_ret[StatusMppHi:StatusMppLo] = P.U_MODE;
    end else begin
      status_ret[StatusSie]  = STATUS_REGW[StatusSpie];
      status_ret[StatusSpie] = 1'b1;
      status_ret[StatusSpp]  = 1'b0;
    end
  end

  trapvec #(.P(P)) u_trapvec (
    .trap      (trap_q),
    .interrupt (intr_q),
    .deleg     (deleg_q),
    .cause     (cause_q),
    .mret      (mret_q),
    .ret_priv  (ret_priv_q),
    .mtvec     (MTVEC_REGW),
    .stvec     (STVEC_REGW),
    .mepc      (MEPC_REGW),
    .sepc      (SEPC_REGW),
    .target    (target),
    .priv      (priv_next)
  );

  always_comb begin
    state_d           = state_q;
    CSRSeqValid       = 1'b0;
    CSRSeqAdr         = '0;
    CSRSeqData        = '0;
    SeqStallM         = 1'b0;
    RedirectValid     = 1'b0;
    RedirectPC        = '0;
    PrivilegeModeNext = '0;
    unique case (state_q)
      StIdle: begin
        if (TrapM) begin
          SeqStallM = 1'b1;
          state_d   = StWrEpc;
        end else if (RetM) begin
          SeqStallM = 1'b1;
          state_d   = StRetStatus;
        end
      end
      StWrEpc: begin
        CSRSeqValid = 1'b1;
        SeqStallM   = 1'b1;
        CSRSeqAdr   = deleg_q ? CsrSepc : CsrMepc;
        CSRSeqData  = {pc_q[P.XLEN-1:1], 1'b0};
        if (CSRSeqReady) state_d = StWrCause;
      end
      StWrCause: begin
        CSRSeqValid              = 1'b1;
        SeqStallM                = 1'b1;
        CSRSeqAdr                = deleg_q ? CsrScause : CsrMcause;
        CSRSeqData[P.XLEN-1]     = intr_q;
        CSRSeqData[3:0]          = cause_q;
        if (CSRSeqReady) state_d = StWrTval;
      end
      StWrTval: begin
        CSRSeqValid = 1'b1;
        SeqStallM   = 1'b1;
        CSRSeqAdr   = deleg_q ? CsrStval : CsrMtval;
        CSRSeqData  = tval_q;
        if (CSRSeqReady) state_d = StWrStatus;
      end
      StWrStatus: begin
        CSRSeqValid = 1'b1;
        SeqStallM   = 1'b1;
        CSRSeqAdr   = CsrMstatus;
        CSRSeqData  = status_trap;
        if (CSRSeqReady) state_d = StRedirect;
      end
      StRetStatus: begin
        CSRSeqValid = 1'b1;
        SeqStallM   = 1'b1;
        CSRSeqAdr   = CsrMstatus;
        CSRSeqData  = status_ret;
        if (CSRSeqReady) state_d = StRedirect;
      end
      StRedirect: begin
        SeqStallM         = 1'b1;
        RedirectValid     = 1'b1;
        RedirectPC        = target;
        PrivilegeModeNext = priv_next;
        state_d           = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_trapseq.sv
// Directed bench for trapseq: trap entry, vectored delegation, backpressure, returns, reset.
module tb_trapseq;
  import trapseq_pkg::*;

  logic        clk, reset_n;
  logic        TrapM, RetM, mretM, sretM, InterruptM, DelegateM;
  logic [3:0]  CauseM;
  logic [31:0] PCM, TvalM;
  logic [1:0]  PrivilegeModeW;
  logic [31:0] STATUS_REGW, MTVEC_REGW, STVEC_REGW, MEPC_REGW, SEPC_REGW;
  logic        CSRSeqValid, CSRSeqReady;
  logic [11:0] CSRSeqAdr;
  logic [31:0] CSRSeqData;
  logic        SeqStallM, RedirectValid;
  logic [31:0] RedirectPC;
  logic [1:0]  PrivilegeModeNext;

  int total = 0;
  int bad   = 0;

  trapseq #(.P(DefaultCfg)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .TrapM             (TrapM),
    .RetM              (RetM),
    .mretM             (mretM),
    .sretM             (sretM),
    .InterruptM        (InterruptM),
    .DelegateM         (DelegateM),
    .CauseM            (CauseM),
    .PCM               (PCM),
    .TvalM             (TvalM),
    .PrivilegeModeW    (PrivilegeModeW),
    .STATUS_REGW       (STATUS_REGW),
    .MTVEC_REGW        (MTVEC_REGW),
    .STVEC_REGW        (STVEC_REGW),
    .MEPC_REGW         (MEPC_REGW),
    .SEPC_REGW         (SEPC_REGW),
    .CSRSeqValid       (CSRSeqValid),
    .CSRSeqReady       (CSRSeqReady),
    .CSRSeqAdr         (CSRSeqAdr),
    .CSRSeqData        (CSRSeqData),
    .SeqStallM         (SeqStallM),
    .RedirectValid     (RedirectValid),
    .RedirectPC        (RedirectPC),
    .PrivilegeModeNext (PrivilegeModeNext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks every sequencer output against the expected tuple.
  task automatic outs(input string tag, input logic v, input logic [11:0] a,
                      input logic [31:0] d, input logic st, input logic rv,
                      input logic [31:0] rpc, input logic [1:0] pm);
    chk({tag, "_valid"}, 32'(CSRSeqValid), 32'(v));
    chk({tag, "_adr"}, 32'(CSRSeqAdr), 32'(a));
    chk({tag, "_data"}, CSRSeqData, d);
    chk({tag, "_stall"}, 32'(SeqStallM), 32'(st));
    chk({tag, "_rv"}, 32'(RedirectValid), 32'(rv));
    chk({tag, "_rpc"}, RedirectPC, rpc);
    chk({tag, "_priv"}, 32'(PrivilegeModeNext), 32'(pm));
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic clr_req;
    TrapM = 0; RetM = 0; mretM = 0; sretM = 0; InterruptM = 0; DelegateM = 0;
  endtask

  task automatic set_trap(input logic [1:0] priv, input logic [3:0] cause, input logic intr,
                          input logic del, input logic [31:0] pc, input logic [31:0] tval);
    TrapM = 1; PrivilegeModeW = priv; CauseM = cause; InterruptM = intr; DelegateM = del;
    PCM = pc; TvalM = tval;
  endtask

  initial begin
    reset_n = 0; CSRSeqReady = 1; clr_req();
    CauseM = 0; PCM = 0; TvalM = 0; PrivilegeModeW = 0;
    STATUS_REGW = 0; MTVEC_REGW = 32'h8000_0000; STVEC_REGW = 32'h8000_1001;
    MEPC_REGW = 32'h8000_2000; SEPC_REGW = 32'h8000_3000;
    #12;
    outs("reset", 0, 12'h0, 0, 0, 0, 0, 2'b00);
    tick(); reset_n = 1;

    // M-mode illegal instruction; MIE=1 going in.
    tick(); STATUS_REGW = 32'h0000_0008;
    set_trap(2'b11, 4'd2, 0, 0, 32'h8000_0104, 32'h13);
    #1 chk("t1_accept_stall", 32'(SeqStallM), 1);
    chk("t1_accept_valid", 32'(CSRSeqValid), 0);
    tick(); clr_req();
    outs("t1_c1", 1, 12'h341, 32'h8000_0104, 1, 0, 0, 0);
    tick(); outs("t1_c2", 1, 12'h342, 32'h2, 1, 0, 0, 0);
    tick(); outs("t1_c3", 1, 12'h343, 32'h13, 1, 0, 0, 0);
    tick(); outs("t1_c4", 1, 12'h300, 32'h0000_1880, 1, 0, 0, 0);
    tick(); outs("t1_c5", 0, 12'h0, 0, 1, 1, 32'h8000_0000, 2'b11);
    tick(); outs("t1_c6", 0, 12'h0, 0, 0, 0, 0, 0);

    // Vectored interrupt delegated to S from U; SIE=1 going in.
    STATUS_REGW = 32'h0000_0002;
    set_trap(2'b00, 4'd5, 1, 1, 32'h0000_0200, 32'h0);
    tick(); clr_req();
    outs("t2_c1", 1, 12'h141, 32'h0000_0200, 1, 0, 0, 0);
    tick(); outs("t2_c2", 1, 12'h142, 32'h8000_0005, 1, 0, 0, 0);
    tick(); outs("t2_c3", 1, 12'h143, 32'h0, 1, 0, 0, 0);
    tick(); outs("t2_c4", 1, 12'h300, 32'h0000_0020, 1, 0, 0, 0);
    tick(); outs("t2_c5", 0, 12'h0, 0, 1, 1, 32'h8000_1014, 2'b01);
    tick(); chk("t2_idle_stall", 32'(SeqStallM), 0);

    // Backpressure in WR_CAUSE; odd PC checks that bit 0 is cleared.
    STATUS_REGW = 32'h0000_0008;
    set_trap(2'b11, 4'd2, 0, 0, 32'h8000_0105, 32'h13);
    tick(); clr_req();
    outs("t3_c1", 1, 12'h341, 32'h8000_0104, 1, 0, 0, 0);
    tick(); CSRSeqReady = 0;
    outs("t3_c2", 1, 12'h342, 32'h2, 1, 0, 0, 0);
    tick(); outs("t3_c3", 1, 12'h342, 32'h2, 1, 0, 0, 0);
    tick(); outs("t3_c4", 1, 12'h342, 32'h2, 1, 0, 0, 0);
    tick(); CSRSeqReady = 1;
    outs("t3_c5", 1, 12'h342, 32'h2, 1, 0, 0, 0);
    tick(); outs("t3_c6", 1, 12'h343, 32'h13, 1, 0, 0, 0);
    tick(); outs("t3_c7", 1, 12'h300, 32'h0000_1880, 1, 0, 0, 0);
    tick(); outs("t3_c8", 0, 12'h0, 0, 1, 1, 32'h8000_0000, 2'b11);
    tick(); chk("t3_idle_stall", 32'(SeqStallM), 0);

    // mret with MPP=01, MPIE=1.
    STATUS_REGW = 32'h0000_0880;
    RetM = 1; mretM = 1;
    #1 chk("t4_accept_stall", 32'(SeqStallM), 1);
    tick(); clr_req();
    outs("t4_c1", 1, 12'h300, 32'h0000_0088, 1, 0, 0, 0);
    tick(); STATUS_REGW = 32'h0000_0088;  // CSR file has taken the write
    outs("t4_c2", 0, 12'h0, 0, 1, 1, 32'h8000_2000, 2'b01);
    tick(); chk("t4_idle_stall", 32'(SeqStallM), 0);

    // sret with SPP=1, SPIE=1.
    STATUS_REGW = 32'h0000_0120;
    RetM = 1; sretM = 1;
    tick(); clr_req();
    outs("t5_c1", 1, 12'h300, 32'h0000_0022, 1, 0, 0, 0);
    tick(); STATUS_REGW = 32'h0000_0022;
    outs("t5_c2", 0, 12'h0, 0, 1, 1, 32'h8000_3000, 2'b01);
    tick();

    // Trap and return together: trap wins.
    STATUS_REGW = 32'h0000_0008;
    set_trap(2'b11, 4'd2, 0, 0, 32'h8000_0104, 32'h13);
    RetM = 1; mretM = 1;
    tick(); clr_req();
    outs("t6_c1", 1, 12'h341, 32'h8000_0104, 1, 0, 0, 0);
    tick(); chk("t6_c2_adr", 32'(CSRSeqAdr), 32'h342);
    tick(); chk("t6_c3_adr", 32'(CSRSeqAdr), 32'h343);
    tick(); outs("t6_c4", 1, 12'h300, 32'h0000_1880, 1, 0, 0, 0);
    tick(); outs("t6_c5", 0, 12'h0, 0, 1, 1, 32'h8000_0000, 2'b11);
    tick(); chk("t6_idle_valid", 32'(CSRSeqValid), 0);

    // Asynchronous reset during WR_TVAL, then a fresh trap.
    set_trap(2'b11, 4'd2, 0, 0, 32'h8000_0104, 32'h13);
    tick(); clr_req();
    tick();
    tick(); chk("t7_tval_adr", 32'(CSRSeqAdr), 32'h343);
    #2 reset_n = 0;
    #1 outs("t7_reset", 0, 12'h0, 0, 0, 0, 0, 2'b00);
    tick(); reset_n = 1;
    tick();
    set_trap(2'b11, 4'd2, 0, 0, 32'h8000_0104, 32'h13);
    tick(); clr_req();
    outs("t7_c1", 1, 12'h341, 32'h8000_0104, 1, 0, 0, 0);
    repeat (5) tick();
    chk("t7_idle_stall", 32'(SeqStallM), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
